// File: rtl/voting_pkg.sv
// Shared definitions for the voting datapath: tally width, candidate count,
// result-resolver FSM states and the tally type.
package voting_pkg;

  localparam int VOTE_W   = 8;
  localparam int NUM_CAND = 4;

  typedef enum logic {IDLE, SCAN} res_state_t;

  typedef logic [VOTE_W-1:0] vote_t;

endpackage

// File: rtl/vote_result_resolver.sv
// vote_result_resolver
//   Snapshots the four candidate tallies on a result request (result mode only)
//   and scans them one candidate per cycle, then reports the leader(s).
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for result_req while mode=1; results held
//   SCAN  | walking snapshot[0..3]; done pulses after the last candidate
//
// Ports
//   clock, reset            single clock, async active-high reset
//   mode                    0 = voting, 1 = result (dropping it aborts a scan)
//   result_req              request, sampled only in IDLE
//   cand1_vote..cand4_vote  per-candidate tallies (index 0..3)
//   busy                    scan in progress
//   done                    one-cycle pulse, result outputs freshly updated
//   winner_id               lowest index among the leaders
//   winner_votes            leading count
//   winner_mask             one-hot/multi-hot set of leaders (empty if no votes)
//   tie                     more than one leader
//   no_votes                every snapshot tally was zero
module vote_result_resolver #(
  parameter int VOTE_W   = voting_pkg::VOTE_W,
  parameter int NUM_CAND = voting_pkg::NUM_CAND
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              result_req,
  input  logic [VOTE_W-1:0] cand1_vote,
  input  logic [VOTE_W-1:0] cand2_vote,
  input  logic [VOTE_W-1:0] cand3_vote,
  input  logic [VOTE_W-1:0] cand4_vote,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner_id,
  output logic [VOTE_W-1:0] winner_votes,
  output logic [3:0]        winner_mask,
  output logic              tie,
  output logic              no_votes
);

  import voting_pkg::*;

  // The port list is written out per candidate, so any other count is illegal.
  if (NUM_CAND != 4) begin : g_bad_num_cand
    $error("vote_result_resolver: NUM_CAND must be 4");
  end

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] popcount(input logic [3:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      c = c + 3'(m[i]);
    end
    return c;
  endfunction

  logic [VOTE_W-1:0] cand_in [4];
  assign cand_in[0] = cand1_vote;
  assign cand_in[1] = cand2_vote;
  assign cand_in[2] = cand3_vote;
  assign cand_in[3] = cand4_vote;

  res_state_t        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [VOTE_W-1:0] run_max_q, run_max_d;
  logic [3:0]        run_mask_q, run_mask_d;
  logic [VOTE_W-1:0] snap_q [4];
  logic              snap_load;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        win_id_q, win_id_d;
  logic [VOTE_W-1:0] win_votes_q, win_votes_d;
  logic [3:0]        win_mask_q, win_mask_d;
  logic              tie_q, tie_d;
  logic              no_votes_q, no_votes_d;

  // One scan step on the current candidate; the final step feeds the result
  // registers directly so done lands on the same edge as the last compare.
  logic [VOTE_W-1:0] cur_vote;
  logic [VOTE_W-1:0] step_max;
  logic [3:0]        step_mask;

  always_comb begin
    cur_vote  = snap_q[idx_q];
    step_max  = run_max_q;
    step_mask = run_mask_q;
    if (cur_vote > run_max_q) begin
      step_max  = cur_vote;
      step_mask = 4'b0001 << idx_q;
    end else if ((cur_vote == run_max_q) && (run_max_q != '0)) begin
      step_mask = run_mask_q | (4'b0001 << idx_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_max_d   = run_max_q;
    run_mask_d  = run_mask_q;
    snap_load   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    win_id_d    = win_id_q;
    win_votes_d = win_votes_q;
    win_mask_d  = win_mask_q;
    tie_d       = tie_q;
    no_votes_d  = no_votes_q;

    case (state_q)
      IDLE: begin
        if (result_req && mode) begin
          state_d    = SCAN;
          idx_d      = 2'd0;
          run_max_d  = '0;
          run_mask_d = 4'b0000;
          snap_load  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SCAN: begin
        if (!mode) begin
          // Abort: previous results stay untouched, no done pulse.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          run_max_d  = step_max;
          run_mask_d = step_mask;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            win_votes_d = step_max;
            win_mask_d  = step_mask;
            win_id_d    = lowest_set(step_mask);
            tie_d       = popcount(step_mask) > 3'd1;
            no_votes_d  = (step_max == '0);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      run_max_q   <= '0;
      run_mask_q  <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_id_q    <= 2'd0;
      win_votes_q <= '0;
      win_mask_q  <= 4'b0000;
      tie_q       <= 1'b0;
      no_votes_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_max_q   <= run_max_d;
      run_mask_q  <= run_mask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_id_q    <= win_id_d;
      win_votes_q <= win_votes_d;
      win_mask_q  <= win_mask_d;
      tie_q       <= tie_d;
      no_votes_q  <= no_votes_d;
      if (snap_load) begin
        for (int i = 0; i < 4; i++) begin
          snap_q[i] <= cand_in[i];
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_id    = win_id_q;
  assign winner_votes = win_votes_q;
  assign winner_mask  = win_mask_q;
  assign tie          = tie_q;
  assign no_votes     = no_votes_q;

endmodule

// File: tb/tb_vote_result_resolver.sv
module tb_vote_result_resolver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       result_req = 1'b0;
  logic [7:0] cand1_vote = '0, cand2_vote = '0, cand3_vote = '0, cand4_vote = '0;
  logic       busy, done, tie, no_votes;
  logic [1:0] winner_id;
  logic [7:0] winner_votes;
  logic [3:0] winner_mask;

  vote_result_resolver dut (
    .clock(clock), .reset(reset), .mode(mode), .result_req(result_req),
    .cand1_vote(cand1_vote), .cand2_vote(cand2_vote),
    .cand3_vote(cand3_vote), .cand4_vote(cand4_vote),
    .busy(busy), .done(done), .winner_id(winner_id), .winner_votes(winner_votes),
    .winner_mask(winner_mask), .tie(tie), .no_votes(no_votes)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] id;
    logic [7:0] votes;
    logic [3:0] mask;
    logic       tie;
    logic       nov;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: leaders are every candidate equal to the maximum, provided it is non-zero.
  function automatic exp_t model(input logic [7:0] a, b, c, d);
    int   v[4];
    int   mx;
    int   cnt;
    exp_t r;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    mx = 0;
    foreach (v[i]) if (v[i] > mx) mx = v[i];
    r.votes = 8'(mx);
    r.mask  = 4'b0000;
    cnt     = 0;
    r.id    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mx > 0 && v[i] == mx) begin
        r.mask[i] = 1'b1;
        r.id      = 2'(i);
        cnt++;
      end
    end
    r.tie = (cnt > 1);
    r.nov = (mx == 0);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no scan outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("winner_id",    32'(winner_id),    32'(e.id));
        chk("winner_votes", 32'(winner_votes), 32'(e.votes));
        chk("winner_mask",  32'(winner_mask),  32'(e.mask));
        chk("tie",          32'(tie),          32'(e.tie));
        chk("no_votes",     32'(no_votes),     32'(e.nov));
      end
    end
  end

  task automatic set_votes(input logic [7:0] a, b, c, d);
    cand1_vote = a; cand2_vote = b; cand3_vote = c; cand4_vote = d;
  endtask

  // Presents a request for one edge; returns #1 after the acceptance edge.
  task automatic start(input logic [7:0] a, b, c, d);
    set_votes(a, b, c, d);
    mode       = 1'b1;
    result_req = 1'b1;
    @(posedge clock);
    #1 result_req = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, "_id"},    32'(winner_id),    32'(e.id));
    chk({tag, "_votes"}, 32'(winner_votes), 32'(e.votes));
    chk({tag, "_mask"},  32'(winner_mask),  32'(e.mask));
    chk({tag, "_tie"},   32'(tie),          32'(e.tie));
    chk({tag, "_nov"},   32'(no_votes),     32'(e.nov));
  endtask

  // Complete scan; optionally re-requests while busy, which must be ignored.
  task automatic full_scan(input logic [7:0] a, b, c, d, input bit req_while_busy);
    start(a, b, c, d);
    exp_q.push_back(model(a, b, c, d));
    last_exp = model(a, b, c, d);
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (req_while_busy) result_req = 1'b1;
    repeat (3) @(posedge clock);
    #1 result_req = 1'b0;
    chk("busy_before_done", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  exp_t zero_exp;

  initial begin
    zero_exp = '{id: 2'd0, votes: 8'd0, mask: 4'd0, tie: 1'b0, nov: 1'b0};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    check_outputs("rst", zero_exp);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed patterns
    full_scan(8'd3, 8'd7, 8'd2, 8'd5, 1'b0);
    full_scan(8'd4, 8'd9, 8'd9, 8'd1, 1'b0);
    full_scan(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
    full_scan(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    full_scan(8'd1, 8'd0, 8'd0, 8'd1, 1'b1);

    // Snapshot isolation with request held high: second scan starts only after done
    start(8'd1, 8'd2, 8'd3, 8'd5);
    result_req = 1'b1;
    exp_q.push_back(model(8'd1, 8'd2, 8'd3, 8'd5));
    cand4_vote = 8'd200;
    repeat (3) begin
      @(posedge clock);
      #1 chk("held_req_busy", 32'(busy), 32'd1);
    end
    @(posedge clock);
    #1 chk("held_req_done", 32'(done), 32'd1);
    @(posedge clock);
    #1 result_req = 1'b0;
    chk("held_req_restart", 32'(busy), 32'd1);
    exp_q.push_back(model(8'd1, 8'd2, 8'd3, 8'd200));
    last_exp = model(8'd1, 8'd2, 8'd3, 8'd200);
    repeat (5) @(posedge clock);
    #1;

    // Request in voting mode is ignored
    mode       = 1'b0;
    result_req = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1 chk("mode0_busy", 32'(busy), 32'd0);
    end
    result_req = 1'b0;
    check_outputs("mode0_hold", last_exp);

    // Abort by dropping mode during the scan
    start(8'd9, 8'd8, 8'd7, 8'd6);
    @(posedge clock);
    @(posedge clock);
    #1 mode = 1'b0;
    @(posedge clock);
    #1 chk("abort_busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clock);
    #1;
    check_outputs("abort_hold", last_exp);
    mode = 1'b1;

    // Reset in the middle of a scan
    start(8'd10, 8'd20, 8'd30, 8'd40);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    check_outputs("midrst", zero_exp);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1 chk("midrst_no_done", 32'(busy), 32'd0);
    full_scan(8'd6, 8'd2, 8'd6, 8'd6, 1'b0);

    // Randomized tallies, frequently from a narrow range to provoke ties
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v[4];
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      foreach (v[i]) v[i] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      full_scan(v[0], v[1], v[2], v[3], ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clock);
    #1 chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
